// File: rtl/lpf_feed_ctrl.sv
// Sequencer for the 16-tap nibble-serial low-pass filter.
// Buffers 8-bit input samples, feeds one sample per filter frame as two
// nibbles (low first), captures and tags the filter result, and flags
// underrun, result overflow and frame-sync loss.
module lpf_feed_ctrl #(
    parameter int FRAME_LEN  = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [3:0]       x_half,
    input  logic             y_valid,
    input  logic [7:0]       y,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_fill,
    input  logic             out_ready,
    output logic [7:0]       underrun_cnt,
    output logic             overflow,
    output logic             sync_err,
    input  logic             clr_err
);

    localparam int SLOT_W = $clog2(FRAME_LEN);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);
    localparam logic [PTR_W:0]    FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [SLOT_W-1:0] slot;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic [7:0]        sample;
    logic [TAG_W-1:0]  frame_tag;
    logic              frame_fill;
    logic [TAG_W-1:0]  tag_cnt;

    logic              feed_edge;
    logic              push;
    logic              pop;
    logic              result_slot;
    logic              load;
    logic              drop;
    logic              stray;

    assign fifo_full  = (fifo_count == FIFO_FULL_CNT);
    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = !fifo_full;

    // Per-cycle control decode: feed edge, FIFO traffic and result disposition.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        feed_edge   = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        result_slot = 1'b0;
        load        = 1'b0;
        drop        = 1'b0;
        stray       = 1'b0;

        feed_edge   = (slot == LAST_SLOT);
        push        = in_valid && !fifo_full;
        // Emptiness is judged on the current count, so a same-edge push
        // into an empty FIFO is not visible to this pop.
        pop         = feed_edge && enable && !fifo_empty;
        result_slot = y_valid && feed_edge;
        load        = result_slot && enable && (!out_valid || out_ready);
        drop        = result_slot && enable && out_valid && !out_ready;
        stray       = y_valid && !feed_edge;
    end

    // Free-running frame slot counter; reset value mirrors the filter's reset state.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            slot <= LAST_SLOT;
        end else if (feed_edge) begin
            slot <= '0;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointers and count define
        // which entries are valid, so clearing the data buys nothing.
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle both take effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Frame sample load on the edge entering slot 0: FIFO head or zero fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample     <= '0;
            frame_tag  <= '0;
            frame_fill <= 1'b0;
            tag_cnt    <= '0;
        end else if (feed_edge) begin
            if (pop) begin
                sample     <= fifo_mem[rd_ptr];
                frame_tag  <= tag_cnt;
                frame_fill <= 1'b0;
                tag_cnt    <= tag_cnt + 1'b1;
            end else begin
                sample     <= '0;
                frame_fill <= 1'b1;
            end
        end
    end

    // Nibble feed: low nibble in slot 1, high nibble in slot 2, zero elsewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_half <= '0;
        end else if (slot == SLOT_W'(0)) begin
            x_half <= sample[3:0];
        end else if (slot == SLOT_W'(1)) begin
            x_half <= sample[7:4];
        end else begin
            x_half <= '0;
        end
    end

    // Result holding register with valid/ready output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_fill  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= y;
            out_tag   <= frame_tag;
            out_fill  <= frame_fill;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Error reporting; clr_err wins over a same-cycle set or increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
            overflow     <= 1'b0;
            sync_err     <= 1'b0;
        end else if (clr_err) begin
            underrun_cnt <= '0;
            overflow     <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            if (feed_edge && enable && fifo_empty && (underrun_cnt != 8'hFF)) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (stray) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lpf_feed_ctrl.sv
// Directed bench for lpf_feed_ctrl. The bench keeps its own slot count from
// reset release and plays the filter's role by driving y/y_valid by hand.
module tb_lpf_feed_ctrl;

    localparam int FRAME_LEN = 20;
    localparam int TAG_W     = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic [3:0]       x_half;
    logic             y_valid;
    logic [7:0]       y;
    logic             out_valid;
    logic [7:0]       out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_fill;
    logic             out_ready;
    logic [7:0]       underrun_cnt;
    logic             overflow;
    logic             sync_err;
    logic             clr_err;

    int checks   = 0;
    int failures = 0;
    int slot     = FRAME_LEN - 1;

    lpf_feed_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .FIFO_DEPTH(4),
        .TAG_W     (TAG_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .x_half      (x_half),
        .y_valid     (y_valid),
        .y           (y),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_fill    (out_fill),
        .out_ready   (out_ready),
        .underrun_cnt(underrun_cnt),
        .overflow    (overflow),
        .sync_err    (sync_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        slot = (slot == FRAME_LEN - 1) ? 0 : slot + 1;
    endtask

    task automatic goto_slot(input int target);
        for (int n = 0; n < 2 * FRAME_LEN; n++) begin
            if (slot == target) break;
            step();
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_x_half"},    32'(x_half),       32'h0);
        check({pfx, "_out_valid"}, 32'(out_valid),    32'h0);
        check({pfx, "_out_data"},  32'(out_data),     32'h0);
        check({pfx, "_out_tag"},   32'(out_tag),      32'h0);
        check({pfx, "_out_fill"},  32'(out_fill),     32'h0);
        check({pfx, "_underrun"},  32'(underrun_cnt), 32'h0);
        check({pfx, "_overflow"},  32'(overflow),     32'h0);
        check({pfx, "_sync_err"},  32'(sync_err),     32'h0);
        check({pfx, "_in_ready"},  32'(in_ready),     32'h1);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        y_valid   = 1'b0;
        y         = 8'h00;
        out_ready = 1'b1;
        clr_err   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst0");
        reset = 1'b0;
        slot  = FRAME_LEN - 1;

        // Test 1: single sample 0x5A, nibble order and first result.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();                              // slot 0, push (no pop: enable=0)
        in_valid = 1'b0;
        enable   = 1'b1;
        goto_slot(FRAME_LEN - 1);
        step();                              // slot 0, pop 0x5A
        check("t1_x_slot0", 32'(x_half), 32'h0);
        step();
        check("t1_x_slot1", 32'(x_half), 32'hA);
        step();
        check("t1_x_slot2", 32'(x_half), 32'h5);
        step();
        check("t1_x_slot3", 32'(x_half), 32'h0);
        goto_slot(FRAME_LEN - 1);
        y_valid = 1'b1;
        y       = 8'h12;
        step();
        y_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid), 32'h1);
        check("t1_out_data",  32'(out_data),  32'h12);
        check("t1_out_tag",   32'(out_tag),   32'h0);
        check("t1_out_fill",  32'(out_fill),  32'h0);
        check("t1_underrun",  32'(underrun_cnt), 32'h1);   // FIFO empty at this feed edge
        step();
        check("t1_out_taken", 32'(out_valid), 32'h0);

        // Test 2: fill the FIFO, back-pressure, tags 0..4 in order.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        slot   = FRAME_LEN - 1;
        enable = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h01;
        step();                              // slot 0: push D0
        enable  = 1'b1;
        in_data = 8'h02;
        step();                              // slot 1: push D1
        in_data = 8'h03;
        step();                              // slot 2: push D2
        in_data = 8'h04;
        step();                              // slot 3: push D3, FIFO full
        check("t2_full_ready", 32'(in_ready), 32'h0);
        in_data = 8'h05;
        goto_slot(FRAME_LEN - 1);
        check("t2_still_full", 32'(in_ready), 32'h0);
        step();                              // slot 0: pop D0, push blocked
        check("t2_ready_after_pop", 32'(in_ready), 32'h1);
        step();                              // slot 1: push D4
        in_valid = 1'b0;
        check("t2_full_again", 32'(in_ready), 32'h0);
        check("t2_x_d0_lo", 32'(x_half), 32'h1);
        for (int k = 0; k < 5; k++) begin
            goto_slot(FRAME_LEN - 1);
            y_valid = 1'b1;
            y       = 8'(8'h30 + k);
            step();
            y_valid = 1'b0;
            check($sformatf("t2_valid_%0d", k), 32'(out_valid), 32'h1);
            check($sformatf("t2_data_%0d", k),  32'(out_data),  32'(8'h30 + k));
            check($sformatf("t2_tag_%0d", k),   32'(out_tag),   32'(k));
            check($sformatf("t2_fill_%0d", k),  32'(out_fill),  32'h0);
            step();
            check($sformatf("t2_x_next_%0d", k), 32'(x_half), (k < 4) ? 32'(k + 2) : 32'h0);
        end

        // Test 3: FIFO now empty, three zero-filled frames counted.
        check("t3_underrun_1", 32'(underrun_cnt), 32'h1);
        step();
        check("t3_x_slot2_zero", 32'(x_half), 32'h0);
        for (int f = 0; f < 2; f++) begin
            goto_slot(FRAME_LEN - 1);
            y_valid = 1'b1;
            y       = 8'(8'h70 + f);
            step();
            y_valid = 1'b0;
            check($sformatf("t3_fill_%0d", f),     32'(out_fill),     32'h1);
            check($sformatf("t3_data_%0d", f),     32'(out_data),     32'(8'h70 + f));
            check($sformatf("t3_underrun_%0d", f), 32'(underrun_cnt), 32'(f + 2));
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t3_underrun_clr", 32'(underrun_cnt), 32'h0);
        check("t3_x_zero", 32'(x_half), 32'h0);

        // Test 4: downstream stalled across two result slots.
        out_ready = 1'b0;
        goto_slot(FRAME_LEN - 1);
        y_valid = 1'b1;
        y       = 8'hA1;
        step();
        y_valid = 1'b0;
        check("t4_held_valid", 32'(out_valid), 32'h1);
        check("t4_held_data",  32'(out_data),  32'hA1);
        check("t4_underrun",   32'(underrun_cnt), 32'h1);
        goto_slot(10);
        check("t4_mid_valid", 32'(out_valid), 32'h1);
        check("t4_mid_data",  32'(out_data),  32'hA1);
        check("t4_mid_fill",  32'(out_fill),  32'h1);
        goto_slot(FRAME_LEN - 1);
        y_valid = 1'b1;
        y       = 8'hB2;
        step();
        y_valid = 1'b0;
        check("t4_drop_data",  32'(out_data),  32'hA1);
        check("t4_drop_valid", 32'(out_valid), 32'h1);
        check("t4_overflow",   32'(overflow),  32'h1);
        check("t4_underrun2",  32'(underrun_cnt), 32'h2);
        out_ready = 1'b1;
        step();
        check("t4_drained", 32'(out_valid), 32'h0);

        // Test 5: stray y_valid, clr_err priority, then mid-frame reset.
        goto_slot(7);
        y_valid = 1'b1;
        y       = 8'hEE;
        clr_err = 1'b1;
        step();                              // slot 8: clear beats stray set
        clr_err = 1'b0;
        check("t5_clr_prio_sync", 32'(sync_err), 32'h0);
        check("t5_clr_overflow",  32'(overflow), 32'h0);
        in_valid = 1'b1;
        in_data  = 8'hC3;
        step();                              // slot 9: stray strobe flagged, push
        y_valid = 1'b0;
        check("t5_sync_err",   32'(sync_err),  32'h1);
        check("t5_out_valid",  32'(out_valid), 32'h0);
        in_data = 8'h4D;
        step();                              // slot 10: second push
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_values("rst1");
        @(posedge clk);
        #1;
        reset = 1'b0;
        slot  = FRAME_LEN - 1;

        // Test 6: enable=0 holds samples, then first pop gets tag 0.
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h91;
        step();
        in_data = 8'h62;
        step();
        in_valid = 1'b0;
        step();
        check("t6_x_off", 32'(x_half), 32'h0);
        goto_slot(FRAME_LEN - 1);
        y_valid = 1'b1;
        y       = 8'h99;
        step();
        y_valid = 1'b0;
        check("t6_no_result",   32'(out_valid),    32'h0);
        check("t6_no_underrun", 32'(underrun_cnt), 32'h0);
        check("t6_no_sync",     32'(sync_err),     32'h0);
        step();
        check("t6_x_zero", 32'(x_half), 32'h0);
        enable = 1'b1;
        goto_slot(FRAME_LEN - 1);
        step();                              // slot 0: pop 0x91
        step();
        check("t6_x_lo", 32'(x_half), 32'h1);
        step();
        check("t6_x_hi", 32'(x_half), 32'h9);
        goto_slot(FRAME_LEN - 1);
        y_valid = 1'b1;
        y       = 8'h5C;
        step();
        y_valid = 1'b0;
        check("t6_valid", 32'(out_valid), 32'h1);
        check("t6_data",  32'(out_data),  32'h5C);
        check("t6_tag",   32'(out_tag),   32'h0);
        check("t6_fill",  32'(out_fill),  32'h0);
        check("t6_underrun", 32'(underrun_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
